bus_control_logic: RTL and testbench

- Upstream front end of the 8259A-compatible interrupt controller, sitting between the CPU bus pins and the control logic block.
- Synchronises and decodes chip_select_n, write_enable_n, read_enable_n and address (A0), and captures the data bus.
- Emits one-cycle command-write strobes (ICW1, ICW2, ICW3, ICW4, OCW1, OCW2, OCW3) plus a level read-enable.
- Owns the ICW initialisation sequencer, so downstream blocks receive strobes that are already qualified by sequence position.

---
 rtl/bus_control_logic.sv | 179 +++++++++++++++++
 tb/tb_bus_control_logic.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_control_logic.sv
// CPU bus front end for the 8259A-style interrupt controller: pin sync, write commit, ICW sequencing.
// BUS_SYNC_EN selects SYNC_STAGES-deep pin synchronisers; otherwise one flop per pin feeds edge detection.
module bus_control_logic #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       chip_select_n,
  input  logic       read_enable_n,
  input  logic       write_enable_n,
  input  logic       address,
  input  logic [7:0] data_bus_in,
  output logic [7:0] internal_data_bus,
  output logic       write_initial_command_word_1,
  output logic       write_initial_command_word_2,
  output logic       write_initial_command_word_3,
  output logic       write_initial_command_word_4,
  output logic       write_initial_command_word_2_4,
  output logic       write_operation_control_word_1,
  output logic       write_operation_control_word_2,
  output logic       write_operation_control_word_3,
  output logic       read,
  output logic       initialization_busy,
  output logic [1:0] debug_state
);

  typedef enum logic [1:0] {
    READY     = 2'd0,
    WAIT_ICW2 = 2'd1,
    WAIT_ICW3 = 2'd2,
    WAIT_ICW4 = 2'd3
  } seq_state_e;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_stages
    $error("SYNC_STAGES must be 2 or 3");
  end

  logic cs_s, we_s, a_s;
  logic rd_cs, rd_re, rd_we;

`ifdef BUS_SYNC_EN
  logic [SYNC_STAGES-1:0] cs_sync_q, we_sync_q, re_sync_q, a_sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cs_sync_q <= '1;
      we_sync_q <= '1;
      re_sync_q <= '1;
      a_sync_q  <= '1;
    end else begin
      cs_sync_q <= {cs_sync_q[SYNC_STAGES-2:0], chip_select_n};
      we_sync_q <= {we_sync_q[SYNC_STAGES-2:0], write_enable_n};
      re_sync_q <= {re_sync_q[SYNC_STAGES-2:0], read_enable_n};
      a_sync_q  <= {a_sync_q[SYNC_STAGES-2:0], address};
    end
  end

  assign cs_s  = cs_sync_q[SYNC_STAGES-1];
  assign we_s  = we_sync_q[SYNC_STAGES-1];
  assign a_s   = a_sync_q[SYNC_STAGES-1];
  assign rd_cs = cs_s;
  assign rd_re = re_sync_q[SYNC_STAGES-1];
  assign rd_we = we_s;
`else
  logic cs_reg_q, we_reg_q, a_reg_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cs_reg_q <= 1'b1;
      we_reg_q <= 1'b1;
      a_reg_q  <= 1'b1;
    end else begin
      cs_reg_q <= chip_select_n;
      we_reg_q <= write_enable_n;
      a_reg_q  <= address;
    end
  end

  assign cs_s  = cs_reg_q;
  assign we_s  = we_reg_q;
  assign a_s   = a_reg_q;
  // Read path bypasses the edge-detect flop so its latency is one cycle.
  assign rd_cs = chip_select_n;
  assign rd_re = read_enable_n;
  assign rd_we = write_enable_n;
`endif

  seq_state_e state_q, state_d;
  logic       we_prev_q, sel_q, sel_d;
  logic       write_address_q;
  logic [7:0] data_q;
  logic       single_q, single_d, icw4_q, icw4_d;
  logic [6:0] strobe_q, strobe_d;  // [0]=ICW1 .. [3]=ICW4, [4]=OCW1 .. [6]=OCW3
  logic       read_q;
  logic       wr_active, we_rise, commit;

  assign wr_active = ~we_s & ~cs_s;
  assign we_rise   = ~we_prev_q & we_s;
  assign commit    = we_rise & sel_q;

  always_comb begin
    state_d  = state_q;
    single_d = single_q;
    icw4_d   = icw4_q;
    strobe_d = '0;
    sel_d    = sel_q;
    if (wr_active) sel_d = 1'b1;
    else if (we_rise) sel_d = 1'b0;
    if (commit) begin
      if (!write_address_q && data_q[4]) begin
        strobe_d[0] = 1'b1;
        single_d    = data_q[1];
        icw4_d      = data_q[0];
        state_d     = WAIT_ICW2;
      end else if (write_address_q) begin
        unique case (state_q)
          WAIT_ICW2: begin
            strobe_d[1] = 1'b1;
            if (!single_q)   state_d = WAIT_ICW3;
            else if (icw4_q) state_d = WAIT_ICW4;
            else             state_d = READY;
          end
          WAIT_ICW3: begin
            strobe_d[2] = 1'b1;
            state_d     = icw4_q ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: begin
            strobe_d[3] = 1'b1;
            state_d     = READY;
          end
          default: strobe_d[4] = 1'b1;
        endcase
      end else if (state_q == READY) begin
        if (data_q[3]) strobe_d[6] = 1'b1;
        else           strobe_d[5] = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q         <= READY;
      we_prev_q       <= 1'b1;
      sel_q           <= 1'b0;
      write_address_q <= 1'b0;
      data_q          <= 8'h00;
      single_q        <= 1'b1;
      icw4_q          <= 1'b0;
      strobe_q        <= '0;
      read_q          <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_prev_q <= we_s;
      sel_q     <= sel_d;
      single_q  <= single_d;
      icw4_q    <= icw4_d;
      strobe_q  <= strobe_d;
      read_q    <= ~rd_re & ~rd_cs & rd_we;
      if (wr_active) begin
        data_q          <= data_bus_in;
        write_address_q <= a_s;
      end
    end
  end

  assign internal_data_bus              = data_q;
  assign write_initial_command_word_1   = strobe_q[0];
  assign write_initial_command_word_2   = strobe_q[1];
  assign write_initial_command_word_3   = strobe_q[2];
  assign write_initial_command_word_4   = strobe_q[3];
  assign write_initial_command_word_2_4 = strobe_q[1] | strobe_q[2] | strobe_q[3];
  assign write_operation_control_word_1 = strobe_q[4];
  assign write_operation_control_word_2 = strobe_q[5];
  assign write_operation_control_word_3 = strobe_q[6];
  assign read                           = read_q;
  assign initialization_busy            = (state_q != READY);
  assign debug_state                    = state_q;

endmodule

// File: tb/tb_bus_control_logic.sv
// Bench for bus_control_logic: directed bus writes with a strobe scoreboard and inline level checks.
module tb_bus_control_logic;
  localparam int SYNC_STAGES = 2;
`ifdef BUS_SYNC_EN
  localparam int READ_LAT = SYNC_STAGES + 1;
`else
  localparam int READ_LAT = 1;
`endif

  // Strobe vector bit positions in scoreboard entries {strobes[6:0], data[7:0]}
  localparam logic [6:0] S_ICW1 = 7'b0000001;
  localparam logic [6:0] S_ICW2 = 7'b0000010;
  localparam logic [6:0] S_ICW3 = 7'b0000100;
  localparam logic [6:0] S_ICW4 = 7'b0001000;
  localparam logic [6:0] S_OCW1 = 7'b0010000;
  localparam logic [6:0] S_OCW2 = 7'b0100000;
  localparam logic [6:0] S_OCW3 = 7'b1000000;
  localparam logic [6:0] S_NONE = 7'b0000000;

  localparam logic [7:0] ST_READY = 8'd0;
  localparam logic [7:0] ST_ICW2  = 8'd1;
  localparam logic [7:0] ST_ICW3  = 8'd2;
  localparam logic [7:0] ST_ICW4  = 8'd3;

  logic       clock = 1'b0;
  logic       reset;
  logic       chip_select_n, read_enable_n, write_enable_n, address;
  logic [7:0] data_bus_in;
  logic [7:0] internal_data_bus;
  logic       icw1, icw2, icw3, icw4, icw2_4, ocw1, ocw2, ocw3;
  logic       read, initialization_busy;
  logic [1:0] debug_state;

  logic [14:0] exp_q[$];
  int tests = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got running want finished");
    $fatal(1, "watchdog");
  end

  bus_control_logic #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clock                          (clock),
    .reset                          (reset),
    .chip_select_n                  (chip_select_n),
    .read_enable_n                  (read_enable_n),
    .write_enable_n                 (write_enable_n),
    .address                        (address),
    .data_bus_in                    (data_bus_in),
    .internal_data_bus              (internal_data_bus),
    .write_initial_command_word_1   (icw1),
    .write_initial_command_word_2   (icw2),
    .write_initial_command_word_3   (icw3),
    .write_initial_command_word_4   (icw4),
    .write_initial_command_word_2_4 (icw2_4),
    .write_operation_control_word_1 (ocw1),
    .write_operation_control_word_2 (ocw2),
    .write_operation_control_word_3 (ocw3),
    .read                           (read),
    .initialization_busy            (initialization_busy),
    .debug_state                    (debug_state)
  );

  // ---------------- scoreboard monitor ----------------
  always @(negedge clock) begin
    logic [6:0]  stb;
    logic [14:0] e;
    stb = {ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1};
    if (stb != 7'd0) begin
      tests++;
      if (icw2_4 !== (icw2 | icw3 | icw4)) begin
        fails++;
        $display("FAIL icw2_4_or: got %b want %b", icw2_4, icw2 | icw3 | icw4);
      end
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_strobe: got strobes %b data %h want none", stb, internal_data_bus);
      end else begin
        e = exp_q.pop_front();
        if ({stb, internal_data_bus} !== e) begin
          fails++;
          $display("FAIL strobe_event: got strobes %b data %h want strobes %b data %h",
                   stb, internal_data_bus, e[14:8], e[7:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // cs_mode: 0 normal, 1 chip select released before write_enable_n, 2 chip select never asserted
  task automatic bus_write(input logic a, input logic [7:0] d, input logic [6:0] exp_stb,
                           input int cs_mode = 0);
    if (exp_stb != S_NONE) exp_q.push_back({exp_stb, d});
    @(posedge clock); #1;
    address        = a;
    data_bus_in    = d;
    chip_select_n  = (cs_mode == 2);
    write_enable_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    if (cs_mode == 1) begin
      chip_select_n = 1'b1;
      @(posedge clock); #1;
    end
    write_enable_n = 1'b1;
    repeat (3) @(posedge clock);
    #1 chip_select_n = 1'b1;
    repeat (4) @(posedge clock);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    chip_select_n = 1'b1;
    read_enable_n = 1'b1;
    write_enable_n = 1'b1;
    address = 1'b0;
    data_bus_in = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    check("rst_strobes", {1'b0, ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1}, 8'h00);
    check("rst_data", internal_data_bus, 8'h00);
    check("rst_read", {7'd0, read}, 8'h00);
    check("rst_busy", {7'd0, initialization_busy}, 8'h00);
    check("rst_state", {6'd0, debug_state}, ST_READY);
    reset = 1'b0;
    repeat (2) @(posedge clock);

    // single, ICW4 required
    bus_write(1'b0, 8'h13, S_ICW1);
    check("icw1_busy", {7'd0, initialization_busy}, 8'h01);
    check("icw1_state", {6'd0, debug_state}, ST_ICW2);
    bus_write(1'b1, 8'h20, S_ICW2);
    check("icw2_state", {6'd0, debug_state}, ST_ICW4);
    check("icw2_busy", {7'd0, initialization_busy}, 8'h01);
    bus_write(1'b1, 8'h01, S_ICW4);
    check("icw4_busy", {7'd0, initialization_busy}, 8'h00);
    bus_write(1'b1, 8'hF0, S_OCW1);
    check("ocw1_data", internal_data_bus, 8'hF0);

    // cascade, no ICW4
    bus_write(1'b0, 8'h10, S_ICW1);
    bus_write(1'b1, 8'h08, S_ICW2);
    check("casc_state3", {6'd0, debug_state}, ST_ICW3);
    bus_write(1'b1, 8'h04, S_ICW3);
    check("casc_ready", {6'd0, debug_state}, ST_READY);
    bus_write(1'b1, 8'h55, S_OCW1);

    // OCW2 / OCW3 in READY
    bus_write(1'b0, 8'h20, S_OCW2);
    bus_write(1'b0, 8'h0B, S_OCW3);

    // OCW2 ignored mid-init, ICW1 restart from WAIT_ICW3
    bus_write(1'b0, 8'h10, S_ICW1);
    bus_write(1'b0, 8'h20, S_NONE);
    check("midinit_state", {6'd0, debug_state}, ST_ICW2);
    bus_write(1'b1, 8'h08, S_ICW2);
    check("restart_pre", {6'd0, debug_state}, ST_ICW3);
    bus_write(1'b0, 8'h12, S_ICW1);
    check("restart_state", {6'd0, debug_state}, ST_ICW2);
    bus_write(1'b1, 8'h33, S_ICW2);
    check("restart_ready", {6'd0, debug_state}, ST_READY);

    // chip select boundaries
    bus_write(1'b1, 8'h77, S_OCW1, 1);
    bus_write(1'b1, 8'h99, S_NONE, 2);
    check("cs_high_nocap", internal_data_bus, 8'h77);

    // read level, latency and write priority
    @(posedge clock); #1;
    chip_select_n = 1'b0;
    read_enable_n = 1'b0;
    check("read_pre", {7'd0, read}, 8'h00);
    repeat (READ_LAT) @(posedge clock);
    #1 check("read_on", {7'd0, read}, 8'h01);
    chip_select_n = 1'b1;
    repeat (READ_LAT) @(posedge clock);
    #1 check("read_cs_off", {7'd0, read}, 8'h00);
    chip_select_n = 1'b0;
    repeat (READ_LAT) @(posedge clock);
    #1 check("read_on2", {7'd0, read}, 8'h01);
    exp_q.push_back({S_OCW1, 8'hC3});
    address = 1'b1;
    data_bus_in = 8'hC3;
    write_enable_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 check("read_wr_prio", {7'd0, read}, 8'h00);
    write_enable_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chip_select_n = 1'b1;
    read_enable_n = 1'b1;
    repeat (4) @(posedge clock);

    // reset mid-sequence
    bus_write(1'b0, 8'h13, S_ICW1);
    bus_write(1'b1, 8'h20, S_ICW2);
    check("prereset_state", {6'd0, debug_state}, ST_ICW4);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("mid_rst_busy", {7'd0, initialization_busy}, 8'h00);
    check("mid_rst_state", {6'd0, debug_state}, ST_READY);
    check("mid_rst_data", internal_data_bus, 8'h00);
    check("mid_rst_strobes", {1'b0, ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1}, 8'h00);
    @(posedge clock); #1;
    reset = 1'b0;
    bus_write(1'b1, 8'h66, S_OCW1);

    repeat (5) @(posedge clock);
    check("sb_drained", exp_q.size()[7:0], 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
